reg_file_dumper: RTL and testbench

Sequential read-out engine for the register file. On a start pulse it walks a contiguous, wrapping range of register addresses through one combinational read port, latches each word, and presents it with its address on a valid/ready stream. It sits beside the register file's second read port and feeds debug/trace or memory-store logic. It is the reader counterpart to the register file's clocked write side.

---
 rtl/reg_file_dumper_if.sv | 28 ++
 rtl/reg_file_dumper.sv | 108 ++++++++++
 tb/tb_reg_file_dumper.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_dumper_if.sv
// Stream and read-port bundle between the register-file dumper and its neighbours.
// slave = dumper side, master = register file / consumer / requester side.
interface reg_file_dumper_if #(
  parameter int W = 8,
  parameter int D = 3
);
  logic         Start;
  logic [D-1:0] StartAddr;
  logic [D:0]   Count;
  logic [D-1:0] RaddrOut;
  logic [W-1:0] RdataIn;
  logic [W-1:0] DataOut;
  logic [D-1:0] AddrTag;
  logic         Valid;
  logic         Ready;
  logic         Busy;
  logic         Done;

  modport master (
    output Start, StartAddr, Count, RdataIn, Ready,
    input  RaddrOut, DataOut, AddrTag, Valid, Busy, Done
  );

  modport slave (
    input  Start, StartAddr, Count, RdataIn, Ready,
    output RaddrOut, DataOut, AddrTag, Valid, Busy, Done
  );
endinterface

// File: rtl/reg_file_dumper.sv
// Walks a wrapping address range through a combinational register-file read port
// and streams each captured word with its address over valid/ready.
//
// state | meaning
// IDLE  | waiting for Start
// FETCH | RaddrOut driven, word captured at the end of this cycle
// SEND  | word presented with Valid, held until Ready
// DONE  | one-cycle completion pulse, then back to IDLE
module reg_file_dumper #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic              Clk,
  input  logic              Reset,
  reg_file_dumper_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [D-1:0] raddr_q, raddr_d;
  logic [D:0]   remaining_q, remaining_d;
  logic [W-1:0] data_q, data_d;
  logic [D-1:0] tag_q, tag_d;
  logic         valid_q, valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  always_comb begin
    state_d     = state_q;
    raddr_d     = raddr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    tag_d       = tag_q;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          if (bus.Count != '0) begin
            raddr_d     = bus.StartAddr;
            remaining_d = bus.Count;
            state_d     = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        data_d  = bus.RdataIn;
        tag_d   = raddr_q;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (valid_q && bus.Ready) begin
          if (remaining_q == (D+1)'(1)) begin
            state_d = S_DONE;
          end else begin
            remaining_d = remaining_q - (D+1)'(1);
            raddr_d     = raddr_q + D'(1);
            state_d     = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered, so derive them from the next state.
    valid_d = (state_d == S_SEND);
    busy_d  = (state_d == S_FETCH) || (state_d == S_SEND);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      raddr_q     <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      tag_q       <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      raddr_q     <= raddr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      tag_q       <= tag_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.RaddrOut = raddr_q;
  assign bus.DataOut  = data_q;
  assign bus.AddrTag  = tag_q;
  assign bus.Valid    = valid_q;
  assign bus.Busy     = busy_q;
  assign bus.Done     = done_q;

endmodule

// File: tb/tb_reg_file_dumper.sv
// Directed bench for reg_file_dumper: a small clocked register-file model feeds the
// read port; each task drives one scenario and checks outputs #1 after the clock edge.
module tb_reg_file_dumper;
  localparam int W = 8;
  localparam int D = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_dumper_if #(.W(W), .D(D)) bus ();

  reg_file_dumper #(.W(W), .D(D)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  logic [W-1:0] regs [2**D];
  logic         we;
  logic [D-1:0] waddr;
  logic [W-1:0] wdata;

  always @(posedge clk) if (we) regs[waddr] <= wdata;
  assign bus.RdataIn = regs[bus.RaddrOut];

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [D-1:0] a, input logic [W-1:0] d);
    we = 1'b1; waddr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  // Pulses Start for one cycle; returns in cycle 1 of the dump.
  task automatic start_dump(input logic [D-1:0] a, input logic [D:0] n);
    bus.Start = 1'b1; bus.StartAddr = a; bus.Count = n;
    tick();
    bus.Start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++;
    if ({bus.RaddrOut, bus.DataOut, bus.AddrTag, bus.Valid, bus.Busy, bus.Done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs raddr=%0h data=%0h tag=%0h v=%0b b=%0b d=%0b want all 0",
               bus.RaddrOut, bus.DataOut, bus.AddrTag, bus.Valid, bus.Busy, bus.Done);
    end
    tick();
    total++;
    if ({bus.Valid, bus.Busy, bus.Done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle vbd=%b want 000", {bus.Valid, bus.Busy, bus.Done});
    end
  endtask

  task automatic test_full_dump();
    logic         ev, eb, ed;
    logic [D-1:0] etag;
    logic [W-1:0] edata;
    bus.Ready = 1'b1;
    start_dump(3'd0, 4'd8);
    for (int c = 1; c <= 18; c++) begin
      ev = (c % 2 == 0) && (c <= 16);
      eb = (c <= 16);
      ed = (c == 17);
      total++;
      if ({bus.Valid, bus.Busy, bus.Done} !== {ev, eb, ed}) begin
        bad++;
        $display("FAIL full_ctrl cycle=%0d vbd=%b want %b", c,
                 {bus.Valid, bus.Busy, bus.Done}, {ev, eb, ed});
      end
      if (ev) begin
        etag  = D'(c / 2 - 1);
        edata = 8'h10 + W'(etag);
        total++;
        if (bus.AddrTag !== etag || bus.DataOut !== edata) begin
          bad++;
          $display("FAIL full_word cycle=%0d tag=%0d data=%0h want tag=%0d data=%0h",
                   c, bus.AddrTag, bus.DataOut, etag, edata);
        end
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [D-1:0] wtag [4];
    int           n;
    logic         seen_done;
    wtag[0] = 3'd6; wtag[1] = 3'd7; wtag[2] = 3'd0; wtag[3] = 3'd1;
    n = 0;
    seen_done = 1'b0;
    bus.Ready = 1'b1;
    start_dump(3'd6, 4'd4);
    for (int c = 1; c <= 20 && !seen_done; c++) begin
      if (bus.Valid && bus.Ready) begin
        if (n < 4) begin
          total++;
          if (bus.AddrTag !== wtag[n] || bus.DataOut !== (8'h10 + W'(wtag[n]))) begin
            bad++;
            $display("FAIL wrap_word idx=%0d tag=%0d data=%0h want tag=%0d data=%0h",
                     n, bus.AddrTag, bus.DataOut, wtag[n], 8'h10 + W'(wtag[n]));
          end
        end
        n++;
      end
      if (bus.Done) seen_done = 1'b1;
      tick();
    end
    total++;
    if (n != 4 || !seen_done) begin
      bad++;
      $display("FAIL wrap_count handshakes=%0d done=%0b want 4 and 1", n, seen_done);
    end
  endtask

  task automatic test_backpressure();
    bus.Ready = 1'b0;
    start_dump(3'd2, 4'd2);
    tick();
    for (int c = 2; c <= 4; c++) begin
      total++;
      if (bus.Valid !== 1'b1 || bus.DataOut !== 8'h12 || bus.AddrTag !== 3'd2 ||
          bus.RaddrOut !== 3'd2 || bus.Busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d v=%0b data=%0h tag=%0d raddr=%0d want 1/12/2/2",
                 c, bus.Valid, bus.DataOut, bus.AddrTag, bus.RaddrOut);
      end
      tick();
    end
    bus.Ready = 1'b1;
    total++;
    if (bus.Valid !== 1'b1 || bus.DataOut !== 8'h12) begin
      bad++;
      $display("FAIL bp_accept v=%0b data=%0h want 1/12", bus.Valid, bus.DataOut);
    end
    tick();
    total++;
    if (bus.Valid !== 1'b0 || bus.RaddrOut !== 3'd3 || bus.Busy !== 1'b1) begin
      bad++;
      $display("FAIL bp_fetch2 v=%0b raddr=%0d b=%0b want 0/3/1", bus.Valid, bus.RaddrOut, bus.Busy);
    end
    tick();
    total++;
    if (bus.Valid !== 1'b1 || bus.AddrTag !== 3'd3 || bus.DataOut !== 8'h13) begin
      bad++;
      $display("FAIL bp_word2 v=%0b tag=%0d data=%0h want 1/3/13", bus.Valid, bus.AddrTag, bus.DataOut);
    end
    tick();
    total++;
    if ({bus.Valid, bus.Busy, bus.Done} !== 3'b001) begin
      bad++;
      $display("FAIL bp_done vbd=%b want 001", {bus.Valid, bus.Busy, bus.Done});
    end
    tick();
  endtask

  task automatic test_zero_count();
    start_dump(3'd3, 4'd0);
    total++;
    if ({bus.Valid, bus.Busy, bus.Done} !== 3'b001) begin
      bad++;
      $display("FAIL zero_done vbd=%b want 001", {bus.Valid, bus.Busy, bus.Done});
    end
    tick();
    total++;
    if ({bus.Valid, bus.Busy, bus.Done} !== 3'b000) begin
      bad++;
      $display("FAIL zero_idle vbd=%b want 000", {bus.Valid, bus.Busy, bus.Done});
    end
    tick();
  endtask

  task automatic test_ignored_start();
    int   n;
    logic seen_done;
    n = 0;
    seen_done = 1'b0;
    bus.Ready = 1'b1;
    start_dump(3'd0, 4'd3);
    for (int c = 1; c <= 30 && !seen_done; c++) begin
      bus.Start = (c == 3);
      bus.StartAddr = 3'd5;
      bus.Count = 4'd1;
      if (bus.Valid && bus.Ready) begin
        total++;
        if (bus.AddrTag !== D'(n) || bus.DataOut !== (8'h10 + W'(n))) begin
          bad++;
          $display("FAIL ign_word idx=%0d tag=%0d data=%0h want tag=%0d data=%0h",
                   n, bus.AddrTag, bus.DataOut, n, 8'h10 + n);
        end
        n++;
      end
      if (bus.Done) begin
        seen_done = 1'b1;
        bus.Start = 1'b1;
      end
      tick();
    end
    bus.Start = 1'b0;
    total++;
    if (n != 3 || !seen_done) begin
      bad++;
      $display("FAIL ign_count handshakes=%0d done=%0b want 3 and 1", n, seen_done);
    end
    for (int c = 0; c < 2; c++) begin
      total++;
      if (bus.Busy !== 1'b0 || bus.Valid !== 1'b0) begin
        bad++;
        $display("FAIL ign_done_start step=%0d b=%0b v=%0b want 0/0", c, bus.Busy, bus.Valid);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bus.Ready = 1'b1;
    start_dump(3'd0, 4'd8);
    for (int c = 1; c < 5; c++) tick();
    total++;
    if (bus.Busy !== 1'b1 || bus.RaddrOut !== 3'd2) begin
      bad++;
      $display("FAIL mid_setup b=%0b raddr=%0d want 1/2", bus.Busy, bus.RaddrOut);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({bus.RaddrOut, bus.DataOut, bus.AddrTag, bus.Valid, bus.Busy, bus.Done} !== '0) begin
      bad++;
      $display("FAIL mid_reset raddr=%0h data=%0h tag=%0h v=%0b b=%0b d=%0b want all 0",
               bus.RaddrOut, bus.DataOut, bus.AddrTag, bus.Valid, bus.Busy, bus.Done);
    end
    tick();
    total++;
    if ({bus.Valid, bus.Busy, bus.Done} !== 3'b000) begin
      bad++;
      $display("FAIL mid_idle vbd=%b want 000", {bus.Valid, bus.Busy, bus.Done});
    end
    start_dump(3'd0, 4'd1);
    tick();
    total++;
    if (bus.Valid !== 1'b1 || bus.AddrTag !== 3'd0 || bus.DataOut !== 8'h10) begin
      bad++;
      $display("FAIL mid_restart v=%0b tag=%0d data=%0h want 1/0/10", bus.Valid, bus.AddrTag, bus.DataOut);
    end
    tick();
    total++;
    if ({bus.Valid, bus.Busy, bus.Done} !== 3'b001) begin
      bad++;
      $display("FAIL mid_done vbd=%b want 001", {bus.Valid, bus.Busy, bus.Done});
    end
    tick();
  endtask

  task automatic test_collision();
    write_reg(3'd4, 8'h16);
    bus.Ready = 1'b1;
    start_dump(3'd4, 4'd1);
    we = 1'b1; waddr = 3'd4; wdata = 8'hAA;
    tick();
    we = 1'b0;
    total++;
    if (bus.Valid !== 1'b1 || bus.AddrTag !== 3'd4 || bus.DataOut !== 8'h16) begin
      bad++;
      $display("FAIL coll_old v=%0b tag=%0d data=%0h want 1/4/16", bus.Valid, bus.AddrTag, bus.DataOut);
    end
    tick();
    tick();
    start_dump(3'd4, 4'd1);
    tick();
    total++;
    if (bus.Valid !== 1'b1 || bus.DataOut !== 8'hAA) begin
      bad++;
      $display("FAIL coll_new v=%0b data=%0h want 1/aa", bus.Valid, bus.DataOut);
    end
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    we = 1'b0; waddr = '0; wdata = '0;
    bus.Start = 1'b0; bus.StartAddr = '0; bus.Count = '0; bus.Ready = 1'b0;
    for (int i = 0; i < 2**D; i++) write_reg(D'(i), W'(8'h10 + i));
    test_reset();
    test_full_dump();
    test_wrap();
    test_backpressure();
    test_zero_count();
    test_ignored_start();
    test_reset_mid();
    test_collision();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
